// File: rtl/mppt_cubic_mc.sv
// Cubic MPPT power-reference sweep: Pref_c = kopt_c * wm_c^3 over N_CH channels using one shared multiplier.
// Optional: define MPPT_PMAX_CLAMP_EN to clamp each written reference to the latched pmax.
module mppt_cubic_mc #(
    parameter int N_CH  = 4,
    parameter int WIDTH = 32,
    parameter int FRAC  = 16
) (
    input  logic                   clk_sim,
    input  logic                   rst_control_n,
    input  logic                   sta_control,
    input  logic [N_CH*WIDTH-1:0]  wm,
    input  logic [N_CH*WIDTH-1:0]  kopt,
    input  logic [WIDTH-1:0]       pmax,
    output logic [N_CH*WIDTH-1:0]  Pref,
    output logic                   busy,
    output logic                   done_finish_Pref
);

    localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;

    typedef enum logic [2:0] {IDLE, SQ, CUBE, GAIN, WRITE, DONE} state_t;

    state_t                 state, state_nx;
    logic [CW-1:0]          c;
    logic [N_CH*WIDTH-1:0]  wm_sh, kopt_sh;
    logic [WIDTH-1:0]       p;
    logic [WIDTH-1:0]       wm_c, kopt_c;
    logic [WIDTH-1:0]       mul_a, mul_b;
    logic [2*WIDTH-1:0]     prod, prod_sh;
    logic [WIDTH-1:0]       mres;
    logic [WIDTH-1:0]       wval;
    logic                   last_ch;

`ifdef MPPT_PMAX_CLAMP_EN
    logic [WIDTH-1:0]       pmax_sh;
`else
    logic                   pmax_unused;
    assign pmax_unused = ^pmax;
`endif

    assign wm_c    = wm_sh[int'(c)*WIDTH +: WIDTH];
    assign kopt_c  = kopt_sh[int'(c)*WIDTH +: WIDTH];
    assign last_ch = (c == CW'(N_CH - 1));

    // The single multiplier is steered by state: wm*wm, p*wm, then p*kopt.
    always_comb begin
        mul_a = wm_c;
        mul_b = wm_c;
        case (state)
            CUBE: mul_a = p;
            GAIN: begin
                mul_a = p;
                mul_b = kopt_c;
            end
            default: ;
        endcase
    end

    assign prod    = {{WIDTH{1'b0}}, mul_a} * {{WIDTH{1'b0}}, mul_b};
    assign prod_sh = prod >> FRAC;
    assign mres    = (|prod_sh[2*WIDTH-1:WIDTH]) ? '1 : prod_sh[WIDTH-1:0];

`ifdef MPPT_PMAX_CLAMP_EN
    assign wval = (p > pmax_sh) ? pmax_sh : p;
`else
    assign wval = p;
`endif

    always_ff @(posedge clk_sim or negedge rst_control_n) begin
        if (!rst_control_n) state <= IDLE;
        else                state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (sta_control) state_nx = SQ;
            SQ:      state_nx = CUBE;
            CUBE:    state_nx = GAIN;
            GAIN:    state_nx = WRITE;
            WRITE:   state_nx = last_ch ? DONE : SQ;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // done is registered on leaving DONE so it lands 4*N_CH+1 edges after the start edge.
    always_ff @(posedge clk_sim or negedge rst_control_n) begin
        if (!rst_control_n) begin
            c                <= '0;
            wm_sh            <= '0;
            kopt_sh          <= '0;
            p                <= '0;
            Pref             <= '0;
            busy             <= 1'b0;
            done_finish_Pref <= 1'b0;
`ifdef MPPT_PMAX_CLAMP_EN
            pmax_sh          <= '0;
`endif
        end else begin
            done_finish_Pref <= 1'b0;
            case (state)
                IDLE: begin
                    if (sta_control) begin
                        wm_sh   <= wm;
                        kopt_sh <= kopt;
`ifdef MPPT_PMAX_CLAMP_EN
                        pmax_sh <= pmax;
`endif
                        c       <= '0;
                        busy    <= 1'b1;
                    end
                end
                SQ, CUBE, GAIN: p <= mres;
                WRITE: begin
                    Pref[int'(c)*WIDTH +: WIDTH] <= wval;
                    if (last_ch) busy <= 1'b0;
                    else         c    <= c + 1'b1;
                end
                DONE: done_finish_Pref <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mppt_cubic_mc.sv
// Scoreboard bench for mppt_cubic_mc (N_CH=4, WIDTH=32, FRAC=16) with hand-computed expected references.
module tb_mppt_cubic_mc;

    localparam int N_CH  = 4;
    localparam int WIDTH = 32;
    localparam int FRAC  = 16;

    typedef struct {
        logic [N_CH*WIDTH-1:0] pref;
        int                    cyc;
    } exp_t;

    logic                  clk_sim = 1'b0;
    logic                  rst_control_n = 1'b0;
    logic                  sta_control = 1'b0;
    logic [N_CH*WIDTH-1:0] wm = '0;
    logic [N_CH*WIDTH-1:0] kopt = '0;
    logic [WIDTH-1:0]      pmax = '1;
    logic [N_CH*WIDTH-1:0] Pref;
    logic                  busy;
    logic                  done_finish_Pref;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    exp_t sb[$];

    mppt_cubic_mc #(.N_CH(N_CH), .WIDTH(WIDTH), .FRAC(FRAC)) dut (
        .clk_sim          (clk_sim),
        .rst_control_n    (rst_control_n),
        .sta_control      (sta_control),
        .wm               (wm),
        .kopt             (kopt),
        .pmax             (pmax),
        .Pref             (Pref),
        .busy             (busy),
        .done_finish_Pref (done_finish_Pref)
    );

    always #5 clk_sim = ~clk_sim;
    always @(posedge clk_sim) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [WIDTH-1:0] clampv(input logic [WIDTH-1:0] v, input logic [WIDTH-1:0] pm);
`ifdef MPPT_PMAX_CLAMP_EN
        return (v > pm) ? pm : v;
`else
        return v;
`endif
    endfunction

    // Monitor: every done pulse must match the oldest expected sweep.
    always @(negedge clk_sim) begin
        if (rst_control_n && done_finish_Pref) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("done_cycle", cyc, e.cyc);
                chk("busy_at_done", {31'd0, busy}, 32'd0);
                for (int i = 0; i < N_CH; i++)
                    chk($sformatf("pref_ch%0d", i), Pref[i*WIDTH +: WIDTH], e.pref[i*WIDTH +: WIDTH]);
            end
        end
    end

    task automatic set_ch(input int ch, input logic [WIDTH-1:0] w, input logic [WIDTH-1:0] k);
        wm[ch*WIDTH +: WIDTH]   = w;
        kopt[ch*WIDTH +: WIDTH] = k;
    endtask

    task automatic start(input logic [N_CH*WIDTH-1:0] exp_pref);
        exp_t e;
        @(negedge clk_sim);
        e.pref = exp_pref;
        e.cyc  = cyc + 1 + 4*N_CH + 1;
        sb.push_back(e);
        sta_control = 1'b1;
        @(negedge clk_sim);
        sta_control = 1'b0;
    endtask

    task automatic drain(input int max_cyc);
        int n = 0;
        while (sb.size() != 0 && n < max_cyc) begin
            @(negedge clk_sim);
            n++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", sb.size(), 0);
            sb.delete();
        end
        repeat (3) @(negedge clk_sim);
    endtask

    logic [N_CH*WIDTH-1:0] e4, esat, eclamp, emix;

    initial begin
        for (int i = 0; i < N_CH; i++) begin
            e4[i*WIDTH +: WIDTH]     = clampv(32'h0004_0000, 32'hFFFF_FFFF);
            esat[i*WIDTH +: WIDTH]   = clampv(32'h0004_0000, 32'hFFFF_FFFF);
            eclamp[i*WIDTH +: WIDTH] = clampv(32'h0004_0000, 32'h0003_0000);
        end
        esat[2*WIDTH +: WIDTH] = 32'hFFFF_FFFF;
        emix = {32'h0006_C000, 32'h0003_0000, 32'h0000_0000, 32'h0000_0000};

        repeat (2) @(negedge clk_sim);
        chk("reset_pref_lo", Pref[31:0], 32'd0);
        chk("reset_pref_hi", Pref[127:96], 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done_finish_Pref}, 32'd0);
        rst_control_n = 1'b1;

        // 2.0^3 * 0.5 = 4.0 on all channels; inputs scrambled right after start.
        for (int i = 0; i < N_CH; i++) set_ch(i, 32'h0002_0000, 32'h0000_8000);
        pmax = 32'hFFFF_FFFF;
        start(e4);
        chk("busy_in_sweep", {31'd0, busy}, 32'd1);
        wm   = '1;
        kopt = '0;
        pmax = '0;
        drain(40);

        // Saturation on channel 2.
        for (int i = 0; i < N_CH; i++) set_ch(i, 32'h0002_0000, 32'h0000_8000);
        set_ch(2, 32'h0100_0000, 32'h0001_0000);
        pmax = 32'hFFFF_FFFF;
        start(esat);
        drain(40);

        // pmax limit (only effective when the clamp is built in).
        for (int i = 0; i < N_CH; i++) set_ch(i, 32'h0002_0000, 32'h0000_8000);
        pmax = 32'h0003_0000;
        start(eclamp);
        repeat (4) @(negedge clk_sim);
        sta_control = 1'b1;
        @(negedge clk_sim);
        sta_control = 1'b0;
        drain(40);
        repeat (25) @(negedge clk_sim);
        chk("busy_after_ignored_start", {31'd0, busy}, 32'd0);

        // Abort mid-sweep, then a fresh sweep with zero-input channels.
        pmax = 32'hFFFF_FFFF;
        for (int i = 0; i < N_CH; i++) set_ch(i, 32'h0002_0000, 32'h0000_8000);
        start(e4);
        repeat (7) @(negedge clk_sim);
        rst_control_n = 1'b0;
        sb.delete();
        #1;
        chk("abort_pref_ch0", Pref[31:0], 32'd0);
        chk("abort_pref_ch1", Pref[63:32], 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk_sim);
        rst_control_n = 1'b1;
        repeat (20) @(negedge clk_sim);
        chk("no_done_after_abort_pref", Pref[31:0], 32'd0);

        set_ch(0, 32'h0000_0000, 32'h0001_0000);
        set_ch(1, 32'h0002_0000, 32'h0000_0000);
        set_ch(2, 32'h0001_0000, 32'h0003_0000);
        set_ch(3, 32'h0003_0000, 32'h0000_4000);
        start(emix);
        drain(40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
